// File: rtl/data_memory_controller.sv
// MEM-stage data memory sequencer: lane-select/extend loads, direct word stores,
// read-modify-write sub-word stores, misalignment rejection and access counters.
module data_memory_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Req,
  input  logic                  WriteEn,
  input  logic [1:0]            Datatype,
  input  logic                  LoadUnsigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  output logic                  Stall,
  output logic                  Done,
  output logic                  Misaligned,
  output logic [31:0]           ReadDataOut,
  output logic [ADDR_WIDTH-3:0] MemAddr,
  output logic                  MemRd,
  output logic                  MemWr,
  output logic [31:0]           MemWData,
  input  logic [31:0]           MemRData,
  output logic [CNT_WIDTH-1:0]  LoadCount,
  output logic [CNT_WIDTH-1:0]  StoreCount
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, DONE} state_t;

  localparam logic [1:0] DT_WORD = 2'd0;
  localparam logic [1:0] DT_HALF = 2'd1;
  localparam logic [1:0] DT_BYTE = 2'd2;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            dt_q;
  logic                  we_q, uns_q, mis_q;
  logic [31:0]           wdata_q, merged_q;
  logic                  req_mis;
  logic [31:0]           load_val, merge_val;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;

  assign req_mis = (Datatype == 2'd3) ||
                   (Datatype == DT_WORD && Address[1:0] != 2'b00) ||
                   (Datatype == DT_HALF && Address[0]);

  // Lane extraction and merge only ever use the latched request.
  always_comb begin
    lane_b    = MemRData[{addr_q[1:0], 3'b000} +: 8];
    lane_h    = MemRData[{addr_q[1], 4'b0000} +: 16];
    load_val  = MemRData;
    merge_val = MemRData;
    case (dt_q)
      DT_HALF: begin
        load_val = {{16{lane_h[15] & ~uns_q}}, lane_h};
        merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      DT_BYTE: begin
        load_val = {{24{lane_b[7] & ~uns_q}}, lane_b};
        merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      default: ;
    endcase
  end

  // Strobes depend on the live request in IDLE; everything is held at 0 in reset
  // so an interrupted read-modify-write can never issue its write.
  always_comb begin
    Stall    = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    if (Rst_n) begin
      case (state)
        IDLE: if (Req) begin
          Stall    = 1'b1;
          MemAddr  = Address[ADDR_WIDTH-1:2];
          MemWData = WriteData;
          if (!req_mis) begin
            MemWr = WriteEn && (Datatype == DT_WORD);
            MemRd = !(WriteEn && (Datatype == DT_WORD));
          end
        end
        RD_WAIT, RMW_RD: begin
          Stall   = 1'b1;
          MemAddr = addr_q[ADDR_WIDTH-1:2];
        end
        RMW_WR: begin
          Stall    = 1'b1;
          MemWr    = 1'b1;
          MemAddr  = addr_q[ADDR_WIDTH-1:2];
          MemWData = merged_q;
        end
        default: ;
      endcase
    end
  end

  assign Done       = (state == DONE);
  assign Misaligned = (state == DONE) && mis_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      dt_q        <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      mis_q       <= 1'b0;
      wdata_q     <= '0;
      merged_q    <= '0;
      ReadDataOut <= '0;
      LoadCount   <= '0;
      StoreCount  <= '0;
    end else begin
      case (state)
        IDLE: if (Req) begin
          addr_q  <= Address;
          dt_q    <= Datatype;
          we_q    <= WriteEn;
          uns_q   <= LoadUnsigned;
          wdata_q <= WriteData;
          mis_q   <= req_mis;
          if (req_mis)                    state <= DONE;
          else if (!WriteEn)              state <= RD_WAIT;
          else if (Datatype == DT_WORD)   state <= DONE;
          else                            state <= RMW_RD;
        end
        RD_WAIT: begin
          ReadDataOut <= load_val;
          state       <= DONE;
        end
        RMW_RD: begin
          merged_q <= merge_val;
          state    <= RMW_WR;
        end
        RMW_WR: state <= DONE;
        DONE: begin
          if (!mis_q) begin
            if (we_q && StoreCount != '1) StoreCount <= StoreCount + 1'b1;
            if (!we_q && LoadCount != '1) LoadCount <= LoadCount + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed plus randomized accesses against a word-array reference of the data memory.
module tb_data_memory_controller;

  localparam int AW = 12;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst_n, Req, WriteEn, LoadUnsigned;
  logic [1:0]    Datatype;
  logic [AW-1:0] Address;
  logic [31:0]   WriteData;
  logic          Stall, Done, Misaligned, MemRd, MemWr;
  logic [31:0]   ReadDataOut, MemWData, MemRData;
  logic [AW-3:0] MemAddr;
  logic [CW-1:0] LoadCount, StoreCount;

  data_memory_controller #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .WriteEn(WriteEn), .Datatype(Datatype),
    .LoadUnsigned(LoadUnsigned), .Address(Address), .WriteData(WriteData),
    .Stall(Stall), .Done(Done), .Misaligned(Misaligned), .ReadDataOut(ReadDataOut),
    .MemAddr(MemAddr), .MemRd(MemRd), .MemWr(MemWr), .MemWData(MemWData),
    .MemRData(MemRData), .LoadCount(LoadCount), .StoreCount(StoreCount)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_rd;
  int          ref_lc, ref_sc;
  int          vectors, miscompares;

  always @(posedge Clk) begin
    if (MemWr) mem[MemAddr] <= MemWData;
    if (MemRd) MemRData <= mem[MemAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit we, input logic [1:0] dt, input bit uns,
                        input logic [AW-1:0] a, input logic [31:0] wd);
    logic [31:0] w, nw, b, mask, wcap;
    int sh, lat, exp_rd_n, exp_wr_n, exp_wr_at, rd_n, wr_n, wr_at, cyc, wi;
    bit mis, both, stall0, addr_ok;
    wi  = int'(a[AW-1:2]);
    w   = ref_mem[wi];
    nw  = w;
    mis = (dt == 2'd3) || (dt == 2'd0 && a[1:0] != 2'd0) || (dt == 2'd1 && a[0]);
    sh  = (dt == 2'd1) ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
    exp_rd_n = 0; exp_wr_n = 0; exp_wr_at = -1;
    if (mis) lat = 1;
    else if (!we) begin
      lat = 2; exp_rd_n = 1;
      if (dt == 2'd0) ref_rd = w;
      else if (dt == 2'd1) begin
        b = (w >> sh) & 32'hFFFF;
        ref_rd = (!uns && b >= 32'h8000) ? b - 32'h10000 : b;
      end else begin
        b = (w >> sh) & 32'hFF;
        ref_rd = (!uns && b >= 32'h80) ? b - 32'h100 : b;
      end
      if (ref_lc != 15) ref_lc++;
    end else begin
      if (dt == 2'd0) begin
        lat = 1; exp_wr_n = 1; exp_wr_at = 0; nw = wd;
      end else begin
        lat = 3; exp_rd_n = 1; exp_wr_n = 1; exp_wr_at = 2;
        mask = ((dt == 2'd1) ? 32'hFFFF : 32'hFF) << sh;
        nw = (w & ~mask) | ((wd << sh) & mask);
      end
      ref_mem[wi] = nw;
      if (ref_sc != 15) ref_sc++;
    end

    @(posedge Clk); #1;
    Req = 1'b1; WriteEn = we; Datatype = dt; LoadUnsigned = uns; Address = a; WriteData = wd;
    #1;
    stall0 = Stall;
    addr_ok = !(MemRd || MemWr) || (MemAddr == a[AW-1:2]);
    cyc = 0; rd_n = 0; wr_n = 0; wr_at = -1; both = 0; wcap = '0;
    while (Done !== 1'b1 && cyc < 8) begin
      if (MemRd === 1'b1) rd_n++;
      if (MemWr === 1'b1) begin wr_n++; wr_at = cyc; wcap = MemWData; end
      if (MemRd === 1'b1 && MemWr === 1'b1) both = 1;
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 1) begin
        WriteEn = 1'($urandom); Datatype = 2'($urandom); LoadUnsigned = 1'($urandom);
        Address = AW'($urandom); WriteData = $urandom;
      end
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("stall_req", 32'(stall0), 32'd1);
    chk("stall_done", 32'(Stall), 32'd0);
    chk("misaligned", 32'(Misaligned), 32'(mis));
    chk("mem_addr", 32'(addr_ok), 32'd1);
    chk("rd_strobes", 32'(rd_n), 32'(exp_rd_n));
    chk("wr_strobes", 32'(wr_n), 32'(exp_wr_n));
    chk("wr_cycle", 32'(wr_at), 32'(exp_wr_at));
    chk("rd_wr_overlap", 32'(both), 32'd0);
    if (exp_wr_n != 0) chk("wdata", wcap, nw);
    chk("read_data", ReadDataOut, ref_rd);
    Req = 1'b0;
    @(posedge Clk); #1;
    chk("load_count", 32'(LoadCount), 32'(ref_lc));
    chk("store_count", 32'(StoreCount), 32'(ref_sc));
    chk("mem_word", mem[wi], ref_mem[wi]);
    chk("mem_next", mem[(wi + 1) % 1024], ref_mem[(wi + 1) % 1024]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {25'd0, Stall, Done, Misaligned, MemRd, MemWr, 2'b00}, 32'd0);
    chk({tag, "_rdata"}, ReadDataOut, 32'd0);
    chk({tag, "_addr_wdata"}, MemWData | 32'(MemAddr), 32'd0);
    chk({tag, "_counts"}, {24'd0, LoadCount, StoreCount}, 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    ref_rd = '0; ref_lc = 0; ref_sc = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'h8899AABB; ref_mem[1] = 32'h8899AABB;
    MemRData = '0;
    Rst_n = 1'b0; Req = 1'b0; WriteEn = 1'b0; Datatype = '0; LoadUnsigned = 1'b0;
    Address = '0; WriteData = '0;
    #12;
    chk_reset_outputs("reset");
    @(negedge Clk); Rst_n = 1'b1;

    access(1'b0, 2'd2, 1'b0, 12'h006, 32'h0);          // lb  -> FFFFFF99
    chk("lb_value", ReadDataOut, 32'hFFFFFF99);
    access(1'b0, 2'd1, 1'b1, 12'h006, 32'h0);          // lhu -> 00008899
    chk("lhu_value", ReadDataOut, 32'h00008899);
    access(1'b0, 2'd1, 1'b0, 12'h004, 32'h0);          // lh  -> FFFFAABB
    chk("lh_value", ReadDataOut, 32'hFFFFAABB);
    access(1'b1, 2'd2, 1'b0, 12'h005, 32'h1234565A);   // sb
    chk("sb_word", mem[1], 32'h88995ABB);
    access(1'b0, 2'd0, 1'b0, 12'h004, 32'h0);          // lw
    chk("lw_value", ReadDataOut, 32'h88995ABB);
    access(1'b1, 2'd0, 1'b0, 12'h008, 32'hDEADBEEF);   // sw
    chk("sw_word", mem[2], 32'hDEADBEEF);
    access(1'b0, 2'd1, 1'b0, 12'h003, 32'h0);          // misaligned lh
    access(1'b1, 2'd3, 1'b0, 12'h00C, 32'h55555555);   // illegal datatype
    chk("illegal_rdata", ReadDataOut, 32'h88995ABB);

    // Reset during the read phase of a halfword read-modify-write.
    @(posedge Clk); #1;
    Req = 1'b1; WriteEn = 1'b1; Datatype = 2'd1; Address = 12'h012; WriteData = 32'hCAFE;
    @(posedge Clk); #3;
    Rst_n = 1'b0; Req = 1'b0;
    #1;
    chk_reset_outputs("mid_rmw");
    repeat (3) @(posedge Clk);
    #1;
    chk("mid_rmw_wr", 32'(MemWr), 32'd0);
    chk("mid_rmw_mem", mem[4], ref_mem[4]);
    @(negedge Clk); Rst_n = 1'b1;
    ref_rd = '0; ref_lc = 0; ref_sc = 0;
    access(1'b1, 2'd1, 1'b0, 12'h012, 32'h0000CAFE);
    access(1'b0, 2'd1, 1'b1, 12'h012, 32'h0);
    chk("after_reset_lhu", ReadDataOut, 32'h0000CAFE);

    for (int n = 0; n < 200; n++)
      access(1'($urandom), 2'($urandom), 1'($urandom), AW'($urandom_range(0, 63)), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
- Sequences every MEM-stage access to the word-wide, synchronous-read data memory.
- Loads: reads the word, selects the addressed byte/halfword lane and sign- or zero-extends it.
- Stores: word stores write directly; sub-word stores run read-modify-write so the other byte lanes are preserved.
- Stalls the pipeline until the access completes and flags misaligned or illegal accesses.

Parameters:
- ADDR_WIDTH, 12, byte-address width; word index = Address[ADDR_WIDTH-1:2].
- CNT_WIDTH, 16, width of the saturating load and store access counters.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Req  input  1  access request from MEM stage; held high until Done.
- WriteEn  input  1  1 = store, 0 = load; sampled when the request is accepted.
- Datatype  input  2  0 = word, 1 = halfword, 2 = byte, 3 = illegal.
- LoadUnsigned  input  1  1 = zero-extend (lbu/lhu), 0 = sign-extend.
- Address  input  ADDR_WIDTH  byte address; little-endian, lane = Address[1:0].
- WriteData  input  32  store data; sub-word stores use the low bits.
- Stall  output  1  freeze the pipeline.
- Done  output  1  one-cycle completion pulse.
- Misaligned  output  1  pulses with Done on an access that is rejected.
- ReadDataOut  output  32  extended load result, registered; holds until the next load completes.
- MemAddr  output  ADDR_WIDTH-2  word index to memory.
- MemRd  output  1  read strobe; MemRData is valid the next cycle.
- MemWr  output  1  write strobe; whole word written at the clock edge.
- MemWData  output  32  word write data.
- MemRData  input  32  memory read data.
- LoadCount  output  CNT_WIDTH  completed, aligned loads; saturating.
- StoreCount  output  CNT_WIDTH  completed, aligned stores; saturating.

Behaviour:
- Reset (async, Rst_n low):
  - State goes to IDLE.
  - All outputs 0, including ReadDataOut and both counters.
  - MemRd and MemWr are forced low combinationally while Rst_n is low, including in the middle of an operation; no partial write is ever issued.
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR, DONE.
- Alignment: an access is misaligned if
  - halfword and Address[0]=1, or
  - word and Address[1:0]!=0, or
  - Datatype=3.
- IDLE with Req=1:
  - Stall=1 combinationally.
  - Address, Datatype, WriteEn, LoadUnsigned and WriteData are latched.
  - Misaligned: no memory strobe; go to DONE, which asserts Misaligned. ReadDataOut and the counters are unchanged.
  - Load: MemRd=1, MemAddr = word index; go to RD_WAIT.
  - Word store: MemWr=1, MemWData=WriteData; go to DONE.
  - Sub-word store: MemRd=1; go to RMW_RD.
- RD_WAIT (Stall=1):
  - Extract lane from MemRData: byte = MemRData[8*A+7 : 8*A]; half = MemRData[16*A[1]+15 : 16*A[1]]; word unchanged.
  - Extend per LoadUnsigned.
  - Register into ReadDataOut at the clock edge; go to DONE.
- RMW_RD (Stall=1):
  - Merge the latched WriteData low byte/half into the addressed lane of MemRData; other lanes unchanged.
  - Register the merged word; go to RMW_WR.
- RMW_WR (Stall=1): MemWr=1 with the merged word; go to DONE.
- DONE:
  - Done=1, Stall=0; Misaligned=1 if the access was rejected.
  - The matching counter increments unless saturated at all-ones or the access was misaligned.
  - Unconditionally go to IDLE; Req is ignored in DONE, so a new request is accepted in the following IDLE cycle.
- Latency, request cycle to Done:
  - Load: 2 cycles.
  - Word store: 1 cycle.
  - Sub-word store: 3 cycles.
  - Misaligned: 1 cycle.
- Input changes after acceptance are ignored; only the latched values are used.
- MemRd and MemWr are never high in the same cycle.

Test Plan:
1. Memory word[1]=0x8899AABB. Signed lb at Address 0x006 -> MemRd pulse in the request cycle; ReadDataOut=0xFFFFFF99 and Done at +2 cycles; LoadCount=1.
2. Same word, lhu (LoadUnsigned=1) at 0x006 -> ReadDataOut=0x00008899. Signed lh at 0x004 -> 0xFFFFAABB.
3. sb WriteData=0x1234565A at 0x005 -> MemRd, then MemWr with MemWData=0x88995ABB; Done at +3 cycles; StoreCount=1. A later lw at 0x004 returns 0x88995ABB.
4. sw 0xDEADBEEF at 0x008 -> MemWr in the request cycle; Done +1; only word[2] changes.
5. lh at 0x003, and a Datatype=3 access -> no MemRd/MemWr; Done and Misaligned together at +1; ReadDataOut and counters unchanged.
6. Rst_n driven low during RMW_RD of an sh -> MemWr never asserted; target word unchanged; all outputs 0; the next request after release completes normally.
